// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operation in on the source side, result out on the sink side.
// The opcode field is op_type because "type" is a reserved word in SystemVerilog.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op_type;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic [3:0]       flags;
    logic [31:0]      op_cnt;

    modport master (
        output in_valid, a, b, op_type, out_ready,
        input  in_ready, out_valid, c, flags, op_cnt
    );

    modport slave (
        input  in_valid, a, b, op_type, out_ready,
        output in_ready, out_valid, c, flags, op_cnt
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined integer ALU: result and flags {err, ovf, carry, zero} are computed at acceptance
// and carried through STAGES elastic register stages, each with its own valid bit.
module alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    logic [STAGES-1:0]            stage_vld;
    logic [STAGES-1:0][WIDTH-1:0] stage_res;
    logic [STAGES-1:0][3:0]       stage_flg;
    logic [31:0]                  op_count;

    logic [STAGES-1:0] load;
    logic [STAGES-1:0] advance;
    logic              accept;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_new;
    logic             carry_new;
    logic             ovf_new;
    logic             err_new;
    logic [3:0]       flags_new;

    assign sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff    = bus.a - bus.b;
    assign shamt   = bus.b[SHW-1:0];

    always_comb begin
        res_new   = '0;
        carry_new = 1'b0;
        ovf_new   = 1'b0;
        err_new   = 1'b0;
        case (bus.op_type)
            OP_ADD: begin
                res_new   = sum_ext[WIDTH-1:0];
                carry_new = sum_ext[WIDTH];
                ovf_new   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                res_new   = diff;
                carry_new = bus.a < bus.b;
                ovf_new   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  res_new = bus.a & bus.b;
            OP_OR:   res_new = bus.a | bus.b;
            OP_XOR:  res_new = bus.a ^ bus.b;
            OP_SLL:  res_new = bus.a << shamt;
            OP_SRL:  res_new = bus.a >> shamt;
            OP_SRA:  res_new = $unsigned($signed(bus.a) >>> shamt);
            OP_SLT:  res_new = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: res_new = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            default: err_new = 1'b1;
        endcase
        flags_new = {err_new, ovf_new, carry_new, res_new == '0};
    end

    // Ready ripples back from the output so an empty stage never stalls the one before it.
    always_comb begin
        load    = '0;
        advance = '0;
        advance[STAGES-1] = stage_vld[STAGES-1] && bus.out_ready;
        load[STAGES-1]    = !stage_vld[STAGES-1] || advance[STAGES-1];
        for (int i = int'(STAGES) - 2; i >= 0; i--) begin
            advance[i] = stage_vld[i] && load[i+1];
            load[i]    = !stage_vld[i] || advance[i];
        end
    end

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= '0;
            stage_res <= '0;
            stage_flg <= '0;
            op_count  <= '0;
        end else begin
            if (load[0]) begin
                stage_vld[0] <= accept;
                stage_res[0] <= res_new;
                stage_flg[0] <= flags_new;
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (load[i]) begin
                    stage_vld[i] <= stage_vld[i-1];
                    stage_res[i] <= stage_res[i-1];
                    stage_flg[i] <= stage_flg[i-1];
                end
            end
            if (advance[STAGES-1]) begin
                op_count <= op_count + 32'd1;
            end
        end
    end

    assign bus.in_ready  = !rst && load[0];
    assign bus.out_valid = stage_vld[STAGES-1];
    assign bus.c         = stage_res[STAGES-1];
    assign bus.flags     = stage_flg[STAGES-1];
    assign bus.op_cnt    = op_count;
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vectors on a 32-bit/2-stage instance, then elastic streams
// under random backpressure on 32/2, 8/1 and 8/4 instances checked against a reference model.
module tb_alu_pipe;
    logic clk;
    logic rst;
    logic rst_s;
    int   n_tests;
    int   n_fail;
    bit   stream_go;
    int   stream_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(32)) mb ();
    alu_pipe #(.WIDTH(32), .STAGES(2)) u_dut (.clk(clk), .rst(rst), .bus(mb));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {err, ovf, carry, zero, c[63:0]} for a w-bit ALU.
    function automatic logic [67:0] model(input int w, input logic [63:0] ai,
                                          input logic [63:0] bi, input logic [3:0] op);
        logic [63:0] mask, a, b, r, sbit;
        logic [64:0] full;
        logic        carry, ovf, err;
        int          sh;
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a     = ai & mask;
        b     = bi & mask;
        sbit  = 64'd1 << (w - 1);
        r     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        sh    = int'(b % 64'(w));
        case (op)
            4'd0: begin
                full  = {1'b0, a} + {1'b0, b};
                r     = full[63:0] & mask;
                carry = full[w];
                ovf   = ((a & sbit) == (b & sbit)) && ((r & sbit) != (a & sbit));
            end
            4'd1: begin
                r     = (a - b) & mask;
                carry = a < b;
                ovf   = ((a & sbit) != (b & sbit)) && ((r & sbit) != (a & sbit));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = (a << sh) & mask;
            4'd6: r = a >> sh;
            4'd7: begin
                r = a >> sh;
                if ((a & sbit) != 0) r = r | (mask & ~(mask >> sh));
            end
            4'd8: r = {63'd0, (a ^ sbit) < (b ^ sbit)};
            4'd9: r = {63'd0, a < b};
            default: err = 1'b1;
        endcase
        return {err, ovf, carry, r == 64'd0, r};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] exp_c,
                          input logic [3:0] exp_f);
        @(negedge clk);
        mb.a         = a;
        mb.b         = b;
        mb.op_type   = op;
        mb.in_valid  = 1'b1;
        mb.out_ready = 1'b1;
        #1 check_eq({tag, "_rdy"}, 64'(mb.in_ready), 64'd1);
        @(negedge clk);
        mb.in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 64'(mb.out_valid), 64'd0);
        @(negedge clk);
        check_eq({tag, "_vld"}, 64'(mb.out_valid), 64'd1);
        check_eq({tag, "_c"}, 64'(mb.c), 64'(exp_c));
        check_eq({tag, "_flags"}, 64'(mb.flags), 64'(exp_f));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_stream
        localparam int unsigned W = (g == 0) ? 32 : 8;
        localparam int unsigned S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        alu_pipe_if #(.WIDTH(W)) sb ();
        alu_pipe #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst_s), .bus(sb));

        initial begin
            logic [67:0] exp_q[$];
            logic [67:0] e;
            logic [63:0] ra, rb;
            logic [3:0]  rop;
            int          sent, got, cyc;
            sb.in_valid  = 1'b0;
            sb.out_ready = 1'b0;
            sb.a         = '0;
            sb.b         = '0;
            sb.op_type   = '0;
            wait (stream_go);
            sent = 0;
            got  = 0;
            cyc  = 0;
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rop  = 4'($urandom_range(0, 15));
            while ((sent < 20 || got < 20) && cyc < 1000) begin
                @(negedge clk);
                cyc++;
                sb.out_ready = ($urandom_range(0, 2) != 0);
                sb.in_valid  = (sent < 20);
                sb.a         = ra[W-1:0];
                sb.b         = rb[W-1:0];
                sb.op_type   = rop;
                #1;
                if (sb.out_valid && sb.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq($sformatf("s%0d_extra", g), 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("s%0d_c%0d", g, got), 64'(sb.c), e[63:0]);
                        check_eq($sformatf("s%0d_f%0d", g, got), 64'(sb.flags), 64'(e[67:64]));
                    end
                    got++;
                end
                if (sb.in_valid && sb.in_ready) begin
                    exp_q.push_back(model(int'(W), ra, rb, rop));
                    sent++;
                    ra  = {$urandom, $urandom};
                    rb  = {$urandom, $urandom};
                    rop = 4'($urandom_range(0, 15));
                end
            end
            sb.in_valid = 1'b0;
            check_eq($sformatf("s%0d_got", g), 64'(got), 64'd20);
            @(negedge clk);
            check_eq($sformatf("s%0d_opcnt", g), 64'(sb.op_cnt), 64'd20);
            stream_done++;
        end
    end

    initial begin
        int          acc, nout, first_cyc, last_cyc;
        logic [31:0] outs[$];
        n_tests      = 0;
        n_fail       = 0;
        stream_go    = 1'b0;
        stream_done  = 0;
        rst          = 1'b1;
        rst_s        = 1'b1;
        mb.in_valid  = 1'b0;
        mb.out_ready = 1'b0;
        mb.a         = '0;
        mb.b         = '0;
        mb.op_type   = '0;
        repeat (2) @(negedge clk);
        mb.in_valid = 1'b1;
        #1;
        check_eq("rst_in_ready", 64'(mb.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(mb.out_valid), 64'd0);
        check_eq("rst_c", 64'(mb.c), 64'd0);
        check_eq("rst_flags", 64'(mb.flags), 64'd0);
        check_eq("rst_opcnt", 64'(mb.op_cnt), 64'd0);
        @(negedge clk);
        mb.in_valid = 1'b0;
        rst   = 1'b0;
        rst_s = 1'b0;
        #1 check_eq("rel_in_ready", 64'(mb.in_ready), 64'd1);

        run_op("add", 32'd5, 32'd7, 4'd0, 32'd12, 4'b0000);
        @(negedge clk);
        check_eq("opcnt1", 64'(mb.op_cnt), 64'd1);
        run_op("add_carry", 32'hFFFF_FFFF, 32'd1, 4'd0, 32'h0, 4'b0011);
        run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'd0, 32'h8000_0000, 4'b0100);
        run_op("sub_borrow", 32'd3, 32'd5, 4'd1, 32'hFFFF_FFFE, 4'b0010);
        run_op("sub_ovf", 32'h8000_0000, 32'd1, 4'd1, 32'h7FFF_FFFF, 4'b0100);
        run_op("sub_zero", 32'd5, 32'd5, 4'd1, 32'h0, 4'b0001);
        run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2, 32'hF000_F000, 4'b0000);
        run_op("or", 32'h0000_000F, 32'h0000_00F0, 4'd3, 32'h0000_00FF, 4'b0000);
        run_op("xor", 32'hAAAA_5555, 32'hFFFF_0000, 4'd4, 32'h5555_5555, 4'b0000);
        run_op("sll", 32'd1, 32'd31, 4'd5, 32'h8000_0000, 4'b0000);
        run_op("srl", 32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 4'b0000);
        run_op("sra", 32'h8000_0000, 32'd35, 4'd7, 32'hF000_0000, 4'b0000);
        run_op("slt", 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd1, 4'b0000);
        run_op("sltu", 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd0, 4'b0001);
        run_op("illegal", 32'd9, 32'd3, 4'd12, 32'd0, 4'b1001);
        @(negedge clk);
        check_eq("opcnt15", 64'(mb.op_cnt), 64'd15);

        // Backpressure: four ADDs (100+k)+k, sink stalled for the first four cycles.
        acc       = 0;
        nout      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            mb.out_ready = (cyc >= 4);
            mb.in_valid  = (acc < 4);
            mb.a         = 32'(100 + acc);
            mb.b         = 32'(acc);
            mb.op_type   = 4'd0;
            #1;
            if (cyc == 3) begin
                check_eq("bp_accepted", 64'(acc), 64'd2);
                check_eq("bp_in_ready", 64'(mb.in_ready), 64'd0);
                check_eq("bp_hold_vld", 64'(mb.out_valid), 64'd1);
                check_eq("bp_hold_c", 64'(mb.c), 64'd100);
            end
            if (mb.out_valid && mb.out_ready) begin
                outs.push_back(mb.c);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nout++;
            end
            if (mb.in_valid && mb.in_ready) acc++;
        end
        mb.in_valid = 1'b0;
        check_eq("bp_nout", 64'(nout), 64'd4);
        check_eq("bp_nogap", 64'(last_cyc - first_cyc), 64'd3);
        for (int k = 0; k < 4; k++) begin
            if (k < outs.size()) begin
                check_eq($sformatf("bp_order%0d", k), 64'(outs[k]), 64'(100 + 2 * k));
            end else begin
                check_eq($sformatf("bp_order%0d", k), 64'hDEAD, 64'(100 + 2 * k));
            end
        end
        @(negedge clk);
        check_eq("opcnt19", 64'(mb.op_cnt), 64'd19);

        // Asynchronous reset with two operations in flight.
        mb.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            mb.in_valid = 1'b1;
            mb.a        = 32'(k + 1);
            mb.b        = 32'd1;
            mb.op_type  = 4'd0;
        end
        @(negedge clk);
        mb.in_valid = 1'b0;
        #1 check_eq("ar_pre_vld", 64'(mb.out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("ar_out_valid", 64'(mb.out_valid), 64'd0);
        check_eq("ar_c", 64'(mb.c), 64'd0);
        check_eq("ar_flags", 64'(mb.flags), 64'd0);
        check_eq("ar_opcnt", 64'(mb.op_cnt), 64'd0);
        check_eq("ar_in_ready", 64'(mb.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst          = 1'b0;
        mb.out_ready = 1'b1;
        #1 check_eq("ar_rel_ready", 64'(mb.in_ready), 64'd1);
        nout = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            #1 if (mb.out_valid) nout++;
        end
        check_eq("ar_no_ghost", 64'(nout), 64'd0);
        check_eq("ar_opcnt_after", 64'(mb.op_cnt), 64'd0);

        stream_go = 1'b1;
        for (int i = 0; i < 3000 && stream_done < 3; i++) @(negedge clk);
        check_eq("streams_done", 64'(stream_done), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of 2).
REQ-002 Parameter STAGES, default 2, pipeline register stages between input and output (legal 1..4).
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port in_valid  input  1  operation presented on a/b/type.
REQ-006 Port in_ready  output  1  block can accept an operation this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B (shift amount = b[log2(WIDTH)-1:0]).
REQ-009 Port type  input  4  opcode.
REQ-010 Port out_valid  output  1  c/flags hold a completed result.
REQ-011 Port out_ready  input  1  downstream accepts result.
REQ-012 Port c  output  WIDTH  result.
REQ-013 Port flags  output  4  {err, ovf, carry, zero}.
REQ-014 Port op_cnt  output  32  count of results accepted downstream.

Function
REQ-015 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT signed, 9 SLTU unsigned; SLT/SLTU result 1 or 0 zero-extended.
REQ-016 Opcodes 10..15 SHALL produce c=0, err=1, other flags 0; all legal opcodes produce err=0.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; carry = carry-out for ADD, borrow (a<b unsigned) for SUB; ovf = signed overflow for ADD/SUB, 0 for all other opcodes; carry 0 for non-ADD/SUB.
REQ-018 zero SHALL equal (c==0) for every opcode, including illegal ones (zero=1).
REQ-019 Result and flags SHALL be computed from a/b/type at acceptance (in_valid && in_ready) and carried through STAGES registers, each with its own valid bit.
REQ-020 Stage i SHALL load when empty or when its content moves to stage i+1 in the same cycle; last stage moves out when out_valid && out_ready.
REQ-021 in_ready SHALL equal "stage 0 empty or stage 0 advancing", combinationally; bubbles collapse so an empty stage never stalls upstream.
REQ-022 Latency: with out_ready held 1, out_valid SHALL rise exactly STAGES cycles after the accepting edge; throughput one op per cycle.
REQ-023 With out_ready=0, out_valid, c, flags SHALL hold stable until accepted; pipeline fills to STAGES entries then in_ready=0.
REQ-024 Simultaneous accept-in and accept-out on a full pipeline SHALL both occur in the same cycle with no loss or duplication.
REQ-025 Results SHALL leave in acceptance order.
REQ-026 op_cnt SHALL increment by 1 per out_valid && out_ready edge and wrap 0xFFFFFFFF -> 0.
REQ-027 in_valid while in_ready=0 SHALL not be accepted; sources hold inputs until accepted.

Reset
REQ-028 On rst assertion, all stage valids, out_valid, c, flags, op_cnt SHALL clear to 0 immediately, independent of clk.
REQ-029 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; none appears after release.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-031 ADD a=5 b=7, out_ready=1 -> c=12, flags=0000, out_valid 2 cycles after accept; op_cnt=1.
REQ-032 ADD 0xFFFFFFFF+1 -> c=0, carry=1, zero=1; ADD 0x7FFFFFFF+1 -> c=0x80000000, ovf=1; SUB 3-5 -> c=0xFFFFFFFE, carry=1.
REQ-033 SRA a=0x80000000 b=35 -> c=0xF0000000 (amount 3); SLT a=-1 b=1 -> 1; SLTU same -> 0; type=12 -> c=0, flags=1001.
REQ-034 out_ready=0, issue 4 back-to-back ops -> 2 accepted, in_ready=0; release out_ready -> 4 results in order, no gaps after first.
REQ-035 Stream 20 ops with random out_ready, compare to reference model -> all match, op_cnt=20; repeat with STAGES=1 and STAGES=4, WIDTH=8.
REQ-036 Assert rst asynchronously with 2 ops in flight -> out_valid=0 same instant; no result after release; op_cnt=0.
